// File: rtl/ssd1306_i2c_tx.sv
// Purpose : byte-level I2C write engine for an SSD1306: START, {addr,W}, control byte, payload, STOP.
// Latency : busy for 116 SCL quarters (4*CLK_DIV clk per SCL period) on a full ACKed write, fewer on NACK.
// Backpr. : start is taken only while idle; requests arriving mid-transfer are dropped, busy flags occupancy.
// Ports   : clk, rst_n (async, active-low) | start, data[7:0], is_cmd (request) |
//           busy (comb, high from the cycle start is seen), ack_err (sticky NACK) | sda (open-drain), scl (push-pull).
module ssd1306_i2c_tx #(
  parameter int         CLK_DIV    = 125,
  parameter logic [6:0] SLAVE_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       is_cmd,
  output logic       busy,
  output logic       ack_err,
  inout  wire        sda,
  output logic       scl
);

  localparam int            QW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_ACK, S_STOP} state_t;

  state_t        state;
  logic [QW-1:0] qcnt;      // clk count inside the current quarter
  logic [1:0]    q;         // quarter index q0..q3 inside the current step
  logic [2:0]    bitn;      // bit being shifted, MSB first
  logic [1:0]    byte_idx;  // 0 = address, 1 = control, 2 = payload
  logic [7:0]    data_r;
  logic          cmd_r;
  logic          busy_reg;
  logic          sda_oe;    // 1 pulls SDA low, 0 releases it
  logic          nack;
  logic          tick;
  logic [7:0]    cur_byte;
  logic          nxt_msb;

  assign tick = (qcnt == QMAX);
  assign busy = busy_reg | (start & ~busy_reg);
  assign sda  = sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    cur_byte = data_r;
    case (byte_idx)
      2'd0:    cur_byte = {SLAVE_ADDR, 1'b0};
      2'd1:    cur_byte = cmd_r ? 8'h00 : 8'h40;
      default: cur_byte = data_r;
    endcase
  end

  // MSB of the byte that follows an ACKed one: both control bytes start with 0.
  assign nxt_msb = (byte_idx == 2'd0) ? 1'b0 : data_r[7];

  // Outputs are registered: at each quarter boundary the levels for the quarter
  // being entered are loaded, so scl/sda change exactly on quarter edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      q        <= 2'd0;
      bitn     <= 3'd0;
      byte_idx <= 2'd0;
      data_r   <= 8'h00;
      cmd_r    <= 1'b0;
      busy_reg <= 1'b0;
      ack_err  <= 1'b0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      nack     <= 1'b0;
    end else if (state == S_IDLE) begin
      qcnt <= '0;
      q    <= 2'd0;
      if (start) begin
        data_r   <= data;
        cmd_r    <= is_cmd;
        byte_idx <= 2'd0;
        ack_err  <= 1'b0;
        busy_reg <= 1'b1;
        state    <= S_START;
        scl      <= 1'b1;
        sda_oe   <= 1'b0;
      end
    end else begin
      qcnt <= tick ? '0 : qcnt + 1'b1;
      if (tick) begin
        q <= q + 2'd1;
        case (state)
          S_START: begin
            case (q)
              2'd0: sda_oe <= 1'b1;   // SDA falls with SCL high: START
              2'd2: scl    <= 1'b0;
              2'd3: begin
                state  <= S_BYTE;
                bitn   <= 3'd7;
                sda_oe <= ~SLAVE_ADDR[6];
              end
              default: ;
            endcase
          end
          S_BYTE: begin
            case (q)
              2'd1: scl <= 1'b1;
              2'd3: begin
                scl <= 1'b0;
                if (bitn == 3'd0) begin
                  state  <= S_ACK;
                  sda_oe <= 1'b0;
                end else begin
                  bitn   <= bitn - 3'd1;
                  sda_oe <= ~cur_byte[bitn - 3'd1];
                end
              end
              default: ;
            endcase
          end
          S_ACK: begin
            case (q)
              2'd1: scl  <= 1'b1;
              2'd2: nack <= sda;      // last clk of q2, mid SCL-high
              2'd3: begin
                scl <= 1'b0;
                if (nack || byte_idx == 2'd2) begin
                  state   <= S_STOP;
                  sda_oe  <= 1'b1;
                  ack_err <= nack;
                end else begin
                  byte_idx <= byte_idx + 2'd1;
                  bitn     <= 3'd7;
                  state    <= S_BYTE;
                  sda_oe   <= ~nxt_msb;
                end
              end
              default: ;
            endcase
          end
          S_STOP: begin
            case (q)
              2'd0: scl    <= 1'b1;
              2'd1: sda_oe <= 1'b0;   // SDA rises with SCL high: STOP
              2'd3: begin
                state    <= S_IDLE;
                busy_reg <= 1'b0;
              end
              default: ;
            endcase
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssd1306_i2c_tx.sv
// Purpose : bench for ssd1306_i2c_tx with a bus-decoding I2C slave model and a byte scoreboard.
// Latency : transactions timed from the accepting edge to busy falling, in clk cycles.
// Backpr. : slave ACKs every byte except the one selected by nack_byte.
`timescale 1ns/1ps
module tb_ssd1306_i2c_tx;

  localparam int CLK_DIV  = 2;
  localparam int FULL_CYC = 4 * (1 + 27 + 1) * CLK_DIV;   // 232
  localparam int NACK0_CYC = 4 * (1 + 9 + 1) * CLK_DIV;   // 88

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       is_cmd = 1'b0;
  logic       busy, ack_err, scl;
  wire        sda;
  logic       slv_drv = 1'b0;

  pullup (sda);
  assign sda = slv_drv ? 1'b0 : 1'bz;

  ssd1306_i2c_tx #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'h3C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data(data), .is_cmd(is_cmd),
    .busy(busy), .ack_err(ack_err), .sda(sda), .scl(scl)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int nack_byte = 3;

  // Bus monitor / slave: decodes START, STOP, bits on SCL rise, drives ACK.
  int   start_cnt = 0, stop_cnt = 0, pulse_cnt = 0, last_pulses = 0;
  int   bitcnt = 0, byte_in_txn = 0;
  logic prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] shreg = 8'h00;

  always @(negedge clk) begin
    if (scl && prev_scl && prev_sda && !sda) begin
      start_cnt++; bitcnt = 0; byte_in_txn = 0; pulse_cnt = 0;
    end else if (scl && prev_scl && !prev_sda && sda) begin
      stop_cnt++; last_pulses = pulse_cnt;
    end else if (scl && !prev_scl) begin
      pulse_cnt++;
      if (bitcnt < 8) begin
        shreg = {shreg[6:0], sda};
        bitcnt++;
        if (bitcnt == 8) obs_q.push_back(shreg);
      end else begin
        bitcnt = 0;
        byte_in_txn++;
      end
    end else if (!scl && prev_scl) begin
      slv_drv = (bitcnt == 8) && (byte_in_txn != nack_byte);
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  // nk: index of the NACKed byte, 3 = all ACKed.
  task automatic run_txn(input logic [7:0] d, input logic c, input int nk,
                         output int cyc, output logic b1, output logic ae1);
    nack_byte = nk;
    exp_q.push_back(8'h78);
    if (nk >= 1) exp_q.push_back(c ? 8'h00 : 8'h40);
    if (nk >= 2) exp_q.push_back(d);
    @(negedge clk); start = 1'b1; data = d; is_cmd = c;
    @(negedge clk); start = 1'b0;
    b1 = busy; ae1 = ack_err;
    cyc = 0;
    while (busy && cyc < 5000) begin cyc++; @(negedge clk); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (scl !== 1'b1) begin n_fail++; $display("FAIL reset_scl: got %b want 1", scl); end
    n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL reset_sda: got %b want released(1)", sda); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0", ack_err); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_cmd_byte();
    int cyc; logic b1, ae1; logic [7:0] e, o; int s0, p0;
    s0 = start_cnt; p0 = stop_cnt;
    run_txn(8'hAE, 1'b1, 3, cyc, b1, ae1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 8'hxx; if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL cmd_bus_byte: got %h want %h", o, e); end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL cmd_extra_bytes: got %0d want 0", obs_q.size()); obs_q.delete(); end
    n_checks++; if (cyc != FULL_CYC) begin n_fail++; $display("FAIL cmd_busy_len: got %0d want %0d", cyc, FULL_CYC); end
    n_checks++; if (ack_err !== 1'b0) begin n_fail++; $display("FAIL cmd_ack_err: got %b want 0", ack_err); end
    n_checks++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin n_fail++; $display("FAIL cmd_start_stop: got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0); end
    // 27 byte/ACK pulses plus the SCL rise that precedes STOP
    n_checks++; if (last_pulses != 28) begin n_fail++; $display("FAIL cmd_scl_pulses: got %0d want 28", last_pulses); end
  endtask

  task automatic test_data_byte();
    int cyc; logic b1, ae1; logic [7:0] e, o; int s0, p0;
    s0 = start_cnt; p0 = stop_cnt;
    run_txn(8'h55, 1'b0, 3, cyc, b1, ae1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 8'hxx; if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL data_bus_byte: got %h want %h", o, e); end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL data_extra_bytes: got %0d want 0", obs_q.size()); obs_q.delete(); end
    n_checks++; if (start_cnt - s0 != 1 || stop_cnt - p0 != 1) begin n_fail++; $display("FAIL data_start_stop: got %0d/%0d want 1/1", start_cnt - s0, stop_cnt - p0); end
  endtask

  task automatic test_nack();
    int cyc; logic b1, ae1; logic [7:0] e, o; int p0;
    p0 = stop_cnt;
    run_txn(8'hA5, 1'b1, 0, cyc, b1, ae1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 8'hxx; if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL nack_bus_byte: got %h want %h", o, e); end
    end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL nack_extra_bytes: got %0d want 0", obs_q.size()); obs_q.delete(); end
    n_checks++; if (cyc != NACK0_CYC) begin n_fail++; $display("FAIL nack_busy_len: got %0d want %0d", cyc, NACK0_CYC); end
    n_checks++; if (ack_err !== 1'b1) begin n_fail++; $display("FAIL nack_ack_err: got %b want 1", ack_err); end
    n_checks++; if (stop_cnt - p0 != 1 || last_pulses != 10) begin n_fail++; $display("FAIL nack_stop_after_9: got stops %0d pulses %0d want 1/10", stop_cnt - p0, last_pulses); end
    // next request must clear the sticky flag as soon as it is accepted
    run_txn(8'h12, 1'b0, 3, cyc, b1, ae1);
    n_checks++; if (ae1 !== 1'b0) begin n_fail++; $display("FAIL nack_clear: got %b want 0", ae1); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 8'hxx; if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL nack_next_byte: got %h want %h", o, e); end
    end
    // NACK on the payload byte: all three bytes sent, flag set
    run_txn(8'hC3, 1'b0, 2, cyc, b1, ae1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 8'hxx; if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL nack2_bus_byte: got %h want %h", o, e); end
    end
    n_checks++; if (cyc != FULL_CYC || ack_err !== 1'b1) begin n_fail++; $display("FAIL nack2_len_flag: got %0d/%b want %0d/1", cyc, ack_err, FULL_CYC); end
    obs_q.delete();
  endtask

  task automatic test_start_ignored();
    int cyc; logic b1, ae1; logic [7:0] e, o; int s0;
    s0 = start_cnt;
    fork
      run_txn(8'h3A, 1'b1, 3, cyc, b1, ae1);
      begin
        repeat (5) begin
          repeat (20) @(negedge clk);
          start = 1'b1; data = 8'($urandom_range(0, 255)); is_cmd = 1'($urandom_range(0, 1));
          @(negedge clk); start = 1'b0;
        end
      end
    join
    repeat (40) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 8'hxx; if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL ign_bus_byte: got %h want %h", o, e); end
    end
    n_checks++; if (obs_q.size() != 0 || start_cnt - s0 != 1) begin n_fail++; $display("FAIL ign_single_txn: got %0d starts %0d extra bytes want 1/0", start_cnt - s0, obs_q.size()); obs_q.delete(); end
    n_checks++; if (cyc != FULL_CYC) begin n_fail++; $display("FAIL ign_busy_len: got %0d want %0d", cyc, FULL_CYC); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic [7:0] e, o; int s0, p0;
    s0 = start_cnt; p0 = stop_cnt;
    nack_byte = 3;
    exp_q.push_back(8'h78); exp_q.push_back(8'h00); exp_q.push_back(8'hA0);
    exp_q.push_back(8'h78); exp_q.push_back(8'h40); exp_q.push_back(8'h3F);
    @(negedge clk); start = 1'b1; data = 8'hA0; is_cmd = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_comb: got %b want 1", busy); end
    @(negedge clk); start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_next_edge: got %b want 1", busy); end
    cyc = 0;
    while (busy && cyc < 5000) begin cyc++; @(negedge clk); end
    // request issued in the very cycle busy falls
    start = 1'b1; data = 8'h3F; is_cmd = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (busy && cyc < 5000) begin cyc++; @(negedge clk); end
    repeat (4) @(negedge clk);
    n_checks++; if (cyc != FULL_CYC) begin n_fail++; $display("FAIL b2b_second_len: got %0d want %0d", cyc, FULL_CYC); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 8'hxx; if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_bus_byte: got %h want %h", o, e); end
    end
    n_checks++; if (start_cnt - s0 != 2 || stop_cnt - p0 != 2) begin n_fail++; $display("FAIL b2b_start_stop: got %0d/%0d want 2/2", start_cnt - s0, stop_cnt - p0); end
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int cyc; logic b1, ae1; logic [7:0] e, o;
    nack_byte = 3;
    @(negedge clk); start = 1'b1; data = 8'hE7; is_cmd = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (105) @(negedge clk);   // inside the control byte
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (scl !== 1'b1) begin n_fail++; $display("FAIL rstmid_scl: got %b want 1", scl); end
    n_checks++; if (sda !== 1'b1) begin n_fail++; $display("FAIL rstmid_sda: got %b want released(1)", sda); end
    n_checks++; if (busy !== 1'b0 || ack_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_err: got %b/%b want 0/0", busy, ack_err); end
    o = 8'hxx; if (obs_q.size() > 0) o = obs_q[0];
    n_checks++; if (obs_q.size() != 1 || o !== 8'h78) begin n_fail++; $display("FAIL rstmid_partial: got %0d bytes first %h want 1 byte 78", obs_q.size(), o); end
    obs_q.delete(); exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_txn(8'h81, 1'b1, 3, cyc, b1, ae1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = 8'hxx; if (obs_q.size() > 0) o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmid_next_byte: got %h want %h", o, e); end
    end
    n_checks++; if (cyc != FULL_CYC || ack_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_next_len: got %0d/%b want %0d/0", cyc, ack_err, FULL_CYC); end
  endtask

  initial begin
    test_reset();
    test_cmd_byte();
    test_data_byte();
    test_nack();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
